// File: rtl/cond_issue_ctrl_pkg.sv
// cond_issue_ctrl_pkg: shared ARM condition codes and issue FSM encoding
package cond_issue_ctrl_pkg;
  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;
  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_e;
endpackage

// File: rtl/cond_issue_ctrl_if.sv
// cond_issue_ctrl_if: ID/EXE issue-control bundle between pipeline and controller
interface cond_issue_ctrl_if #(parameter int CNT_W = 16);
  logic idValid;
  logic [3:0] idCond;
  logic idSetFlags;
  logic idReadsCarry;
  logic [3:0] exeStatus;
  logic freeze;
  logic branchTaken;
  logic [3:0] statusOut;
  logic condPass;
  logic issueValid;
  logic stall;
  logic [CNT_W-1:0] squashCount;
  modport master (
    output idValid, idCond, idSetFlags, idReadsCarry, exeStatus, freeze, branchTaken,
    input statusOut, condPass, issueValid, stall, squashCount
  );
  modport slave (
    input idValid, idCond, idSetFlags, idReadsCarry, exeStatus, freeze, branchTaken,
    output statusOut, condPass, issueValid, stall, squashCount
  );
endinterface

// File: rtl/cond_issue_ctrl_cond_eval.sv
// cond_eval: ARM condition-field evaluation against NZCV
module cond_eval
  import cond_issue_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;
  // decode the condition field into a pass/fail for the given flags
  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      EQ: pass = z;
      NE: pass = ~z;
      CS: pass = c;
      CC: pass = ~c;
      MI: pass = n;
      PL: pass = ~n;
      VS: pass = v;
      VC: pass = ~v;
      HI: pass = c & ~z;
      LS: pass = ~c | z;
      GE: pass = n == v;
      LT: pass = n != v;
      GT: pass = ~z & (n == v);
      LE: pass = z | (n != v);
      AL: pass = 1'b1;
      NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/cond_issue_ctrl.sv
// cond_issue_ctrl: conditional-issue control with flag hazard stall/forwarding
module cond_issue_ctrl
  import cond_issue_ctrl_pkg::*;
#(
  parameter bit FORWARD_EN = 1'b0,
  parameter int CNT_W      = 16
) (
  input logic clk,
  input logic rst,
  cond_issue_ctrl_if.slave bus
);
  state_e state;
  logic exeValid, exeSetFlags, exeHot, hazard, stallC, pass, issueC;
  logic [3:0] statusReg, effFlags;
  logic [CNT_W-1:0] squashReg;
  assign exeHot   = exeValid & exeSetFlags;
  assign hazard   = bus.idValid & ((bus.idCond != 4'(AL)) | bus.idReadsCarry) & exeHot;
  assign stallC   = (state == RUN) & hazard & ~FORWARD_EN & ~bus.freeze & ~bus.branchTaken;
  assign effFlags = (FORWARD_EN && exeHot) ? bus.exeStatus : statusReg;
  assign issueC   = bus.idValid & pass & ~stallC & ~bus.branchTaken & ~bus.freeze;
  cond_eval uEval (.cond(bus.idCond), .nzcv(effFlags), .pass(pass));
  // EXE tracking, flag commit, bubble FSM and squash counter; freeze holds all
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      exeValid    <= 1'b0;
      exeSetFlags <= 1'b0;
      statusReg   <= 4'b0000;
      squashReg   <= '0;
    end else if (!bus.freeze) begin
      state       <= stallC ? BUBBLE : RUN;
      exeValid    <= issueC;
      exeSetFlags <= bus.idSetFlags;
      statusReg   <= exeHot ? bus.exeStatus : statusReg;
      if (bus.idValid & ~pass & ~stallC & ~bus.branchTaken & ~&squashReg)
        squashReg <= squashReg + 1'b1;
    end
  end
  assign bus.statusOut   = statusReg;
  assign bus.condPass    = pass;
  assign bus.issueValid  = issueC;
  assign bus.stall       = stallC;
  assign bus.squashCount = squashReg;
endmodule
